vram_port_arbiter: RTL and testbench

- Shares the single-port VGA frame-buffer RAM between three requesters:
  - the VGA scan-out reader;
  - the UART pixel receiver, which supplies address/data/flag words and has no backpressure;
  - an internal frame-clear engine.
- Sits between the UART receiver, the VGA timing/pixel generator and the block RAM.
- Queues UART writes in a small FIFO so no pixel is lost while the reader holds the port.

---
 rtl/vga_mem_pkg.sv | 15 +
 rtl/wr_fifo.sv | 52 +++++
 rtl/vram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_vram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared frame-buffer constants and the arbiter control-state encoding.
package vga_mem_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;
  // 800 x 600 visible pixels, one word each
  localparam int FRAME_WORDS = 800 * 600;
  localparam logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO holding queued UART {address, data} words.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (PTR_W + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full queue is still honoured when a pop frees a slot this cycle
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads first, then the clear engine, then queued UART writes.
module vram_port_arbiter #(
  parameter int ADDR_W      = vga_mem_pkg::ADDR_W,
  parameter int DATA_W      = vga_mem_pkg::DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = vga_mem_pkg::FRAME_WORDS,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = vga_mem_pkg::CLEAR_VALUE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_req,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          vga_rd_en,
  input  logic [ADDR_W-1:0]             vga_rd_addr,
  output logic [DATA_W-1:0]             vga_rd_data,
  output logic                          vga_rd_valid,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          clear_busy,
  output logic                          overflow,
  output logic                          addr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fsm_state
);

  import vga_mem_pkg::*;

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              grant_clear;
  logic              clear_last;
  logic              addr_ok;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;

  assign vga_rd_data = ram_rdata;
  assign fsm_state   = (state == CLEAR);

  // Port grant and FIFO handshake. push/pop are qualified here so the FIFO
  // never sees a push it would have to reject: a full FIFO accepts only
  // when the same cycle pops the head.
  always_comb begin
    grant_clear = !vga_rd_en && (state == CLEAR);
    pop         = !vga_rd_en && (state == IDLE) && !fifo_empty;
    addr_ok     = (wr_addr <= LAST_ADDR);
    push        = wr_valid && addr_ok && (!fifo_full || pop);
    clear_last  = grant_clear && (clr_cnt == LAST_ADDR);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (clear_req) state_next = CLEAR;
      CLEAR: begin
        if (clear_req)       state_next = CLEAR;
        else if (clear_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clear_busy <= 1'b0;
    end else begin
      state      <= state_next;
      clear_busy <= (state_next == CLEAR);
    end
  end

  // Clear counter saturates at the last frame address; a new request restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (clear_req) begin
      clr_cnt <= '0;
    end else if (grant_clear && !clear_last) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (state == IDLE && clear_req) begin
        overflow <= 1'b0;
        addr_err <= 1'b0;
      end
      if (wr_valid && !addr_ok) addr_err <= 1'b1;
      if (wr_valid && addr_ok && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      vga_rd_valid <= 1'b0;
    end else begin
      vga_rd_valid <= vga_rd_en;
      ram_en       <= vga_rd_en || grant_clear || pop;
      ram_we       <= grant_clear || pop;
      if (vga_rd_en) begin
        ram_addr <= vga_rd_addr;
      end else if (grant_clear) begin
        ram_addr  <= clr_cnt;
        ram_wdata <= CLEAR_VALUE;
      end else if (pop) begin
        ram_addr  <= head[ENT_W-1:DATA_W];
        ram_wdata <= head[DATA_W-1:0];
      end
    end
  end

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a small frame (16 words) and a behavioural block RAM.
module tb_vram_port_arbiter;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear_req = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              vga_rd_en = 1'b0;
  logic [ADDR_W-1:0] vga_rd_addr = '0;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              clear_busy;
  logic              overflow;
  logic              addr_err;
  logic [2:0]        fifo_level;
  logic              fsm_state;

  logic [DATA_W-1:0] mem [32];

  int n_vec = 0;
  int n_err = 0;

  // Clock and reset
  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_WORDS (FRAME),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .vga_rd_en    (vga_rd_en),
    .vga_rd_addr  (vga_rd_addr),
    .vga_rd_data  (vga_rd_data),
    .vga_rd_valid (vga_rd_valid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .clear_busy   (clear_busy),
    .overflow     (overflow),
    .addr_err     (addr_err),
    .fifo_level   (fifo_level),
    .fsm_state    (fsm_state)
  );

  // Behavioural single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[4:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[4:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic uart_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    int exp_cnt;
    int busy_cycles;
    bit popped;

    for (int i = 0; i < 32; i++) mem[i] = 16'h7777;

    // Reset state
    tick();
    tick();
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_flags", {30'd0, overflow, addr_err}, 0);
    check("rst_state", 32'(fsm_state), 0);
    rst = 1'b1;
    tick();

    // Single UART write with VGA idle
    uart_word(21'd5, 16'hA55A);
    tick();
    wr_valid = 1'b0;
    check("w1_level_q", 32'(fifo_level), 1);
    check("w1_no_access", 32'(ram_en), 0);
    tick();
    check("w1_we", 32'(ram_we), 1);
    check("w1_addr", 32'(ram_addr), 5);
    check("w1_data", 32'(ram_wdata), 32'hA55A);
    check("w1_level", 32'(fifo_level), 0);
    tick();
    check("w1_idle", 32'(ram_en), 0);

    // VGA holds the port for 10 cycles while three words arrive
    vga_rd_en   = 1'b1;
    vga_rd_addr = 21'd100;
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 3) uart_word(ADDR_W'(i), 16'h1000 + 16'(i));
      else wr_valid = 1'b0;
      tick();
      check("stall_no_write", 32'(ram_we), 0);
    end
    check("stall_level", 32'(fifo_level), 3);
    check("stall_rd_addr", 32'(ram_addr), 100);
    check("stall_rd_valid", 32'(vga_rd_valid), 1);
    vga_rd_en = 1'b0;
    wr_valid  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("drain_we", 32'(ram_we), 1);
      check("drain_addr", 32'(ram_addr), 32'(k));
      check("drain_data", 32'(ram_wdata), 32'h1000 + 32'(k));
    end
    tick();
    check("drain_idle", 32'(ram_en), 0);
    check("drain_level", 32'(fifo_level), 0);
    check("drain_rd_valid", 32'(vga_rd_valid), 0);

    // Overflow: five words into a four-entry queue while VGA blocks
    vga_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uart_word(ADDR_W'(6 + i), 16'h2000 + 16'(i));
      tick();
    end
    wr_valid = 1'b0;
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_flag", 32'(overflow), 1);
    tick();
    check("ovf_sticky", 32'(overflow), 1);
    vga_rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ovf_drain_addr", 32'(ram_addr), 32'(6 + k));
      check("ovf_drain_data", 32'(ram_wdata), 32'h2000 + 32'(k));
    end
    tick();
    check("ovf_5th_dropped", 32'(ram_en), 0);
    check("ovf_still_set", 32'(overflow), 1);

    // Out-of-frame address is dropped
    uart_word(21'd480000, 16'hDEAD);
    tick();
    wr_valid = 1'b0;
    check("aerr_flag", 32'(addr_err), 1);
    check("aerr_level", 32'(fifo_level), 0);
    tick();
    check("aerr_no_write", 32'(ram_en), 0);

    // Full clear with a VGA read and a UART word landing mid-clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_busy", 32'(clear_busy), 1);
    check("clr_state", 32'(fsm_state), 1);
    check("clr_ovf_cleared", 32'(overflow), 0);
    check("clr_aerr_cleared", 32'(addr_err), 0);
    check("clr_first_idle", 32'(ram_en), 0);
    exp_cnt     = 0;
    busy_cycles = 0;
    popped      = 1'b0;
    for (int c = 0; c < 19; c++) begin
      vga_rd_en   = (c == 6);
      vga_rd_addr = 21'd3;
      if (c == 8) uart_word(21'd3, 16'hBEEF);
      else wr_valid = 1'b0;
      if (clear_busy) busy_cycles++;
      tick();
      check("clr_rd_valid", 32'(vga_rd_valid), 32'(c == 6));
      if (c == 6) begin
        check("clr_pause_we", 32'(ram_we), 0);
        check("clr_pause_addr", 32'(ram_addr), 3);
      end else if (exp_cnt < FRAME) begin
        check("clr_we", 32'(ram_we), 1);
        check("clr_addr", 32'(ram_addr), 32'(exp_cnt));
        check("clr_data", 32'(ram_wdata), 0);
        exp_cnt++;
      end else if (!popped) begin
        check("clr_uart_addr", 32'(ram_addr), 3);
        check("clr_uart_data", 32'(ram_wdata), 32'hBEEF);
        popped = 1'b1;
      end else begin
        check("clr_done_idle", 32'(ram_en), 0);
      end
    end
    vga_rd_en = 1'b0;
    check("clr_busy_cycles", 32'(busy_cycles), 17);
    check("clr_back_idle", 32'(fsm_state), 0);
    check("clr_mem15", 32'(mem[15]), 0);
    check("clr_mem0", 32'(mem[0]), 0);
    check("clr_mem3_uart", 32'(mem[3]), 32'hBEEF);

    // Read back through the pass-through data path
    vga_rd_en   = 1'b1;
    vga_rd_addr = 21'd3;
    tick();
    vga_rd_en = 1'b0;
    check("rb_valid", 32'(vga_rd_valid), 1);
    tick();
    check("rb_data", 32'(vga_rd_data), 32'hBEEF);

    // Asynchronous reset in the middle of a clear with a queued word
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    uart_word(21'd2, 16'h1234);
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("arst_pre_addr", 32'(ram_addr), 6);
    check("arst_pre_level", 32'(fifo_level), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ram_en", 32'(ram_en), 0);
    check("arst_ram_we", 32'(ram_we), 0);
    check("arst_ram_addr", 32'(ram_addr), 0);
    check("arst_ram_wdata", 32'(ram_wdata), 0);
    check("arst_busy", 32'(clear_busy), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_state", 32'(fsm_state), 0);
    check("arst_rd_valid", 32'(vga_rd_valid), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arst_no_write", 32'(ram_en), 0);
    end
    check("arst_mem2_untouched", 32'(mem[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
